// File: rtl/stone_drawer.sv
// Read-only scanner of the stone RAM: walks entries 0..quantity-1 each frame and
// rasterises every visible entry as a clipped 16x16 solid sprite, one pixel per cycle.
module stone_drawer #(
  parameter logic [9:0] SCREEN_W       = 10'd320,
  parameter logic [8:0] SCREEN_H       = 9'd240,
  parameter logic [2:0] COLOUR_STONE   = 3'b111,
  parameter logic [2:0] COLOUR_GOLD    = 3'b110,
  parameter logic [2:0] COLOUR_DIAMOND = 3'b011
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] ram_q,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_DRAW = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  function automatic logic [2:0] type_colour(input logic [1:0] stone_type);
    case (stone_type)
      2'b00:   type_colour = COLOUR_STONE;
      2'b01:   type_colour = COLOUR_GOLD;
      default: type_colour = COLOUR_DIAMOND;
    endcase
  endfunction

  state_t      state_r, nxt_state_s;
  logic [3:0]  qty_r, nxt_qty_s;
  logic [3:0]  idx_r, nxt_idx_s;
  logic        flag_r, nxt_flag_s;
  logic [8:0]  ent_x_r, nxt_ent_x_s;
  logic [7:0]  ent_y_r, nxt_ent_y_s;
  logic [1:0]  ent_type_r, nxt_ent_type_s;
  logic [7:0]  cnt_r, nxt_cnt_s;
  logic [8:0]  vga_x_r, nxt_vga_x_s;
  logic [7:0]  vga_y_r, nxt_vga_y_s;
  logic [2:0]  colour_r, nxt_colour_s;
  logic        plot_r, nxt_plot_s;
  logic        done_r, nxt_done_s;

  logic [8:0]  pix_x_base_s;
  logic [7:0]  pix_y_base_s;
  logic [1:0]  pix_type_s;
  logic [7:0]  pix_cnt_s;
  logic [9:0]  x_sum_s;
  logic [8:0]  y_sum_s;
  logic        pix_on_s;
  logic        unused_ram_bits_s;

  // The moving flag and the reserved fields never affect drawing.
  assign unused_ram_bits_s = ^{ram_q[22:19], ram_q[10:4], ram_q[0]};

  // Pixel being prepared for the next cycle: first pixel straight from ram_q, later ones from the entry register.
  always_comb begin
    pix_x_base_s = ent_x_r;
    pix_y_base_s = ent_y_r;
    pix_type_s   = ent_type_r;
    pix_cnt_s    = cnt_r + 8'd1;
    if (state_r == S_WAIT) begin
      pix_x_base_s = ram_q[31:23];
      pix_y_base_s = ram_q[18:11];
      pix_type_s   = ram_q[3:2];
      pix_cnt_s    = 8'd0;
    end else begin
      pix_cnt_s    = cnt_r + 8'd1;
    end
    x_sum_s  = {1'b0, pix_x_base_s} + {6'd0, pix_cnt_s[3:0]};
    y_sum_s  = {1'b0, pix_y_base_s} + {5'd0, pix_cnt_s[7:4]};
    pix_on_s = (x_sum_s < SCREEN_W) && (y_sum_s < SCREEN_H);
  end

  // Next-state and next registered outputs; every output is the registered image of these values.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_qty_s      = qty_r;
    nxt_idx_s      = idx_r;
    nxt_flag_s     = flag_r;
    nxt_ent_x_s    = ent_x_r;
    nxt_ent_y_s    = ent_y_r;
    nxt_ent_type_s = ent_type_r;
    nxt_cnt_s      = cnt_r;
    nxt_vga_x_s    = vga_x_r;
    nxt_vga_y_s    = vga_y_r;
    nxt_colour_s   = 3'd0;
    nxt_plot_s     = 1'b0;
    nxt_done_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          nxt_qty_s   = quantity;
          nxt_idx_s   = 4'd0;
          nxt_flag_s  = 1'b1;
          nxt_state_s = (quantity == 4'd0) ? S_DONE : S_ADDR;
        end else begin
          nxt_state_s = S_IDLE;
        end
      end
      S_ADDR: nxt_state_s = S_WAIT;
      S_WAIT: begin
        nxt_ent_x_s    = ram_q[31:23];
        nxt_ent_y_s    = ram_q[18:11];
        nxt_ent_type_s = ram_q[3:2];
        if (ram_q[1]) begin
          nxt_state_s  = S_DRAW;
          nxt_cnt_s    = 8'd0;
          nxt_vga_x_s  = x_sum_s[8:0];
          nxt_vga_y_s  = y_sum_s[7:0];
          nxt_colour_s = type_colour(pix_type_s);
          nxt_plot_s   = pix_on_s;
        end else begin
          nxt_state_s  = S_NEXT;
        end
      end
      S_DRAW: begin
        if (cnt_r == 8'd255) begin
          nxt_state_s  = S_NEXT;
        end else begin
          nxt_cnt_s    = pix_cnt_s;
          nxt_vga_x_s  = x_sum_s[8:0];
          nxt_vga_y_s  = y_sum_s[7:0];
          nxt_colour_s = type_colour(pix_type_s);
          nxt_plot_s   = pix_on_s;
        end
      end
      S_NEXT: begin
        // Compared at 5 bits so quantity=15 stops at index 14 without wrapping.
        if (({1'b0, idx_r} + 5'd1) >= {1'b0, qty_r}) begin
          nxt_state_s = S_DONE;
        end else begin
          nxt_idx_s   = idx_r + 4'd1;
          nxt_state_s = S_ADDR;
        end
      end
      S_DONE: begin
        nxt_done_s  = 1'b1;
        nxt_flag_s  = 1'b0;
        nxt_state_s = S_IDLE;
      end
      default: begin
        nxt_flag_s  = 1'b0;
        nxt_state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r    <= S_IDLE;
      qty_r      <= 4'd0;
      idx_r      <= 4'd0;
      flag_r     <= 1'b0;
      ent_x_r    <= 9'd0;
      ent_y_r    <= 8'd0;
      ent_type_r <= 2'd0;
      cnt_r      <= 8'd0;
      vga_x_r    <= 9'd0;
      vga_y_r    <= 8'd0;
      colour_r   <= 3'd0;
      plot_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      qty_r      <= nxt_qty_s;
      idx_r      <= nxt_idx_s;
      flag_r     <= nxt_flag_s;
      ent_x_r    <= nxt_ent_x_s;
      ent_y_r    <= nxt_ent_y_s;
      ent_type_r <= nxt_ent_type_s;
      cnt_r      <= nxt_cnt_s;
      vga_x_r    <= nxt_vga_x_s;
      vga_y_r    <= nxt_vga_y_s;
      colour_r   <= nxt_colour_s;
      plot_r     <= nxt_plot_s;
      done_r     <= nxt_done_s;
    end
  end

  assign draw_stone_flag = flag_r;
  assign draw_index      = idx_r;
  assign vga_x           = vga_x_r;
  assign vga_y           = vga_y_r;
  assign colour          = colour_r;
  assign plot            = plot_r;
  assign done            = done_r;

endmodule

// File: tb/tb_stone_drawer.sv
// Randomised and directed bench for stone_drawer: a RAM model feeds entries and a
// list-based sprite model predicts every plotted pixel, scan length and done timing.
module tb_stone_drawer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  quantity = 4'd0;
  logic [31:0] ram_q;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  colour;
  logic        plot;
  logic        done;

  logic [31:0] mem [16];
  logic [3:0]  addr_r = 4'd0;
  int vectors = 0;
  int miscompares = 0;

  stone_drawer dut (
    .clock(clock), .resetn(resetn), .start(start), .quantity(quantity), .ram_q(ram_q),
    .draw_stone_flag(draw_stone_flag), .draw_index(draw_index), .vga_x(vga_x),
    .vga_y(vga_y), .colour(colour), .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM: address registered, data valid the following cycle.
  always @(posedge clock) addr_r <= draw_index;
  assign ram_q = mem[addr_r];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_entry(input int x, input int y, input int t,
                                           input int vis, input int mv, input bit junk);
    logic [31:0] e;
    e = junk ? $urandom : 32'd0;
    e[31:23] = x[8:0];
    e[18:11] = y[7:0];
    e[3:2]   = t[1:0];
    e[1]     = vis[0];
    e[0]     = mv[0];
    return e;
  endfunction

  // repulse_at: cycle to re-pulse start (-1 none, -2 the S_DONE cycle)
  task automatic run_scan(input int q, input int repulse_at);
    logic [31:0] exp_q[$];
    int exp_done, done_cyc, flag_cnt, last_idx, exp_idx, pulse_cyc, x, y;
    logic [31:0] e;
    logic [2:0] col;
    exp_done = 1;
    for (int i = 0; i < q; i++) begin
      e = mem[i];
      if (e[1]) begin
        exp_done += 259;
        col = (e[3:2] == 2'b00) ? 3'b111 : (e[3:2] == 2'b01) ? 3'b110 : 3'b011;
        for (int c = 0; c < 256; c++) begin
          x = int'(e[31:23]) + c % 16;
          y = int'(e[18:11]) + c / 16;
          if (x < 320 && y < 240) exp_q.push_back((x << 11) | (y << 3) | int'(col));
        end
      end else begin
        exp_done += 3;
      end
    end
    pulse_cyc = (repulse_at == -2) ? exp_done - 1 : repulse_at;
    @(negedge clock);
    quantity = q[3:0];
    start = 1'b1;
    @(posedge clock);
    done_cyc = -1; flag_cnt = 0; last_idx = -1; exp_idx = 0;
    for (int cyc = 0; cyc < exp_done + 8 && done_cyc < 0; cyc++) begin
      @(negedge clock);
      start = (cyc == pulse_cyc) ? 1'b1 : 1'b0;
      quantity = 4'($urandom);
      if (draw_stone_flag) begin
        flag_cnt++;
        if (int'(draw_index) != last_idx) begin
          chk("index_seq", {28'd0, draw_index}, exp_idx);
          exp_idx++;
          last_idx = int'(draw_index);
        end
      end
      if (plot) begin
        if (exp_q.size() == 0) chk("extra_plot", 32'd1, 32'd0);
        else chk("pixel", {12'd0, vga_x, vga_y, colour}, exp_q.pop_front());
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, exp_done);
    chk("flag_cycles", flag_cnt, exp_done);
    chk("pixels_left", exp_q.size(), 32'd0);
    @(negedge clock);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("flag_idle", {31'd0, draw_stone_flag}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (3) @(negedge clock);
    chk("rst_flag", {31'd0, draw_stone_flag}, 32'd0);
    chk("rst_index", {28'd0, draw_index}, 32'd0);
    chk("rst_xy", {15'd0, vga_x, vga_y}, 32'd0);
    chk("rst_colour", {29'd0, colour}, 32'd0);
    chk("rst_plot", {31'd0, plot}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    mem[0] = mk_entry(100, 50, 1, 1, 0, 1'b0);
    run_scan(1, -1);

    mem[0] = mk_entry(10, 10, 0, 1, 0, 1'b0);
    mem[1] = mk_entry(10, 10, 0, 0, 0, 1'b0);
    mem[2] = mk_entry(10, 10, 0, 1, 0, 1'b0);
    run_scan(3, -1);

    mem[0] = mk_entry(310, 230, 2, 1, 0, 1'b0);
    run_scan(1, -1);

    run_scan(0, -1);

    mem[1] = mk_entry(200, 100, 3, 1, 0, 1'b1);
    run_scan(2, 100);
    run_scan(1, -2);

    // Reset during a sprite: next cycle must be idle with no pixel strobe.
    mem[0] = mk_entry(20, 20, 1, 1, 0, 1'b0);
    @(negedge clock);
    quantity = 4'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    chk("pre_rst_plot", {31'd0, plot}, 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_plot", {31'd0, plot}, 32'd0);
    chk("midrst_flag", {31'd0, draw_stone_flag}, 32'd0);
    chk("midrst_index", {28'd0, draw_index}, 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    mem[0] = mk_entry(50, 60, 0, 1, 1, 1'b1);
    run_scan(1, -1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = mk_entry($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 3),
                          ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1), 1'b1);
      run_scan($urandom_range(0, 15), ($urandom_range(0, 1) != 0) ? -2 : $urandom_range(0, 400));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
